// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter with optional ownership lock in front of a single
// synchronous data-memory port; routes each read response back to its issuer.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [DATA_W/8-1:0]   be0,
    input  logic [DATA_W/8-1:0]   be1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    owner_t              owner;
    owner_t              owner_nxt;
    logic                prio;
    logic                resp_pend;
    logic                resp_port;
    logic [DATA_W-1:0]   rdata_q0;
    logic [DATA_W-1:0]   rdata_q1;

    // Ownership state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) owner <= IDLE;
        else     owner <= owner_nxt;
    end

    // Lock is taken on a locked grant and dropped on an unlocked grant or when the owner abandons req
    always_comb begin
        owner_nxt = owner;
        case (owner)
            IDLE: begin
                if (gnt0 && lock0)      owner_nxt = OWN0;
                else if (gnt1 && lock1) owner_nxt = OWN1;
            end
            OWN0:    if (!req0 || (gnt0 && !lock0)) owner_nxt = IDLE;
            OWN1:    if (!req1 || (gnt1 && !lock1)) owner_nxt = IDLE;
            default: owner_nxt = IDLE;
        endcase
    end

    // Grant decode and memory-port mux; grants are held off while in reset
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = BE_W'(0);
        if (!rst) begin
            case (owner)
                IDLE: begin
                    if (req0 && (!req1 || !prio)) gnt0 = 1'b1;
                    else if (req1)                gnt1 = 1'b1;
                end
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
        end
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_be    = be0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_be    = be1;
        end
    end

    assign mem_en = gnt0 | gnt1;

    // Priority rotation and read-response tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio      <= 1'b0;
            resp_pend <= 1'b0;
            resp_port <= 1'b0;
            rdata_q0  <= '0;
            rdata_q1  <= '0;
        end else begin
            if (gnt0)      prio <= 1'b1;
            else if (gnt1) prio <= 1'b0;
            resp_pend <= (gnt0 && !we0) || (gnt1 && !we1);
            resp_port <= gnt1;
            if (resp_pend && !resp_port) rdata_q0 <= mem_rdata;
            if (resp_pend &&  resp_port) rdata_q1 <= mem_rdata;
        end
    end

    // RAM data is passed straight through in the response cycle and held afterwards
    assign rvalid0 = resp_pend && !resp_port;
    assign rvalid1 = resp_pend &&  resp_port;
    assign rdata0  = rvalid0 ? mem_rdata : rdata_q0;
    assign rdata1  = rvalid1 ? mem_rdata : rdata_q1;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single synchronous data-memory port of the RISC-V core between the CPU load/store unit (port 0) and the debug/program loader (port 1). Grants at most one transaction per cycle with round-robin fairness and an optional lock for multi-cycle atomic sequences. Routes each read response back to the port that issued it. Sits between the core's data-memory interface and the data RAM instance.

## Interface

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  transaction request, port 0 / port 1
- we0, we1  in  1  1 = write, 0 = read
- lock0, lock1  in  1  keep ownership after this transaction
- addr0, addr1  in  ADDR_W  byte address
- wdata0, wdata1  in  DATA_W  write data
- be0, be1  in  DATA_W/8  byte enables
- gnt0, gnt1  out  1  request accepted this cycle (combinational)
- rvalid0, rvalid1  out  1  read data valid (registered)
- rdata0, rdata1  out  DATA_W  read data, valid only with rvalid
- mem_en  out  1  memory access this cycle
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  muxed from granted port
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_en with mem_we=0

## Operation

- State: prio (1 bit, port holding priority on conflict), owner (IDLE / OWN0 / OWN1), resp_pend (1 bit), resp_port (1 bit).
- IDLE arbitration: only one req -> grant it; both -> grant port prio; after any grant prio <= other port.
- Lock: grant to port n with lockn=1 -> owner <= OWNn. In OWNn only port n may be granted; other port's req waits (gnt=0) regardless of prio.
- Lock release: in OWNn, granted transaction with lockn=0 -> IDLE; reqn=0 in any cycle while OWNn -> IDLE that edge (lock abandon). prio still toggles per grant.
- mem_en = gnt0 | gnt1. mem_* fields copy granted port; when mem_en=0, mem_we=0, mem_be=0, addr/wdata don't-care (drive 0).
- Read grant sets resp_pend=1, resp_port=granted port at the edge; next cycle rvalid of that port =1, rdata of that port = mem_rdata (registered capture). Other port's rdata holds its last value.
- Write grant: no response, resp_pend=0 next cycle.
- Back-to-back reads fully pipelined: one read per cycle, responses in grant order, one cycle each.
- Requester holds req/we/addr/wdata/be/lock stable until gnt; dropping req before gnt is legal (no transaction).

## Timing

- Reset (async, immediate): gnt0=gnt1=0 (combinational, forced low while rst=1), rvalid0=rvalid1=0, rdata0=rdata1=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, prio=port 0, owner=IDLE, resp_pend=0.
- Grant latency: 0 cycles (gnt in same cycle as req when eligible). Read latency: rvalid exactly 1 cycle after gnt cycle.
- Throughput: 1 transaction/cycle total; with both ports requesting continuously and no lock, grants alternate 0,1,0,1.
- Starvation bound: unlocked port waits at most 1 cycle; behind a lock, until lock release.
- Reset asserted with a read in flight: pending rvalid is lost, never emitted after rst deasserts.
- Simultaneous lock release by owner and req by other port: the other port is eligible from the next cycle.
- rvalid for port n never coincides with a gnt to port n being blocked; the response path is independent of grants.

## Test plan

- Reset: hold rst=1 with req0=req1=1 -> gnt0=gnt1=0, mem_en=0, rvalid=0; release rst -> first grant to port 0.
- Single read: port 0 reads addr 0x10, RAM holds 0xDEADBEEF -> gnt0=1 cycle N, mem_addr=0x10, rvalid0=1 and rdata0=0xDEADBEEF cycle N+1, rvalid1=0.
- Contention: req0/req1 both held 4 cycles, reads of 0x0 and 0x4 -> grants 0,1,0,1; rvalid alternates 0,1,0,1 one cycle later with correct data.
- Write then read: port 1 writes 0x12345678 be=0xF to 0x20, then reads 0x20 -> mem_we=1 on first grant, no rvalid; rdata1=0x12345678 one cycle after second grant.
- Lock: port 1 issues 3 reads with lock1=1,1,0 while req0 held -> gnt1 three consecutive cycles, gnt0=0, then gnt0=1 on the fourth cycle.
- Reset mid-read: assert rst in cycle after a read grant, before edge -> rvalid stays 0, no response after rst drops.
